instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   PC/fetch stage sitting directly upstream of instr_mem: owns the program counter, drives
//   pc_addr into instr_mem's combinational read port and registers the returned word into a
//   fetch->decode pipeline register. Implements MIPS branch-delay-slot sequencing, stall hold,
//   branch-during-stall buffering, halt on jump to HALT_ADDR, and misaligned-target trapping.
// PARAMETERS
//   RESET_VECTOR  32'hBFC00000  PC value loaded by reset
//   HALT_ADDR     32'h00000000  loading this into PC ends execution (active falls)
// PORTS
//   clk            in   1   clock, all state updates on rising edge
//   rst_n          in   1   asynchronous, active-low reset
//   stall          in   1   hold all registers this cycle (downstream not ready)
//   branch_taken   in   1   decode: instr_out is a taken branch/jump this cycle
//   branch_target  in   32  decode: target address, valid with branch_taken
//   instr_in       in   32  word read from instr_mem at pc_addr (same cycle)
//   pc_addr        out  32  current PC = instr_mem address (direct from PC register)
//   instr_out      out  32  registered instruction to decode
//   pc_out         out  32  address instr_out was fetched from
//   instr_valid    out  1   instr_out holds a real instruction
//   delay_slot     out  1   instr_out is the delay slot of the preceding branch
//   active         out  1   high while running; low once halted
//   addr_error     out  1   sticky: misaligned branch_target seen
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_VECTOR, state=RUN, instr_out=0, pc_out=0, instr_valid=0,
//     delay_slot=0, active=1, addr_error=0, pend_target=0. Reset mid-operation discards all state.
//   States: RUN, PEND (branch accepted during stall, target buffered), HALTED.
//   Latency: instr_in sampled at edge; instr_out/pc_out valid 1 cycle after pc_addr presented.
//   RUN, stall=0 edge: instr_out<=instr_in, pc_out<=pc, instr_valid<=1,
//     delay_slot<=branch_taken; pc<=branch_taken ? branch_target : pc+4 (32-bit wrap, no carry).
//     Instruction fetched in the branch's decode cycle is the delay slot; it always issues.
//   RUN, stall=1 edge: instr_out/pc_out/instr_valid/delay_slot/pc hold. If branch_taken=1:
//     pend_target<=branch_target, state->PEND (branch captured exactly once).
//   PEND, stall=1: hold everything; branch_taken ignored (decode holds the same branch).
//   PEND, stall=0 edge: issue delay slot as in RUN with delay_slot<=1, pc<=pend_target, ->RUN.
//   Halt: whenever pc would be loaded with HALT_ADDR (seq, branch or pend), the load still
//     happens and state->HALTED on the same edge. HALTED: next edge instr_valid<=0,
//     delay_slot<=0, active<=0; pc frozen at HALT_ADDR; stall/branch_taken ignored; exit by reset only.
//   Misaligned target (branch_target[1:0]!=0 when accepted): addr_error<=1, pc not updated,
//     state->HALTED (delay slot still issues on that edge). HALT_ADDR check uses aligned targets only.
//   Priority per edge: rst_n > HALTED > stall > branch_taken > sequential.
// TESTING
//   1 Reset release, stall=0: edge1 -> pc_out=BFC00000, instr_out=mem[BFC00000], valid=1,
//     pc_addr=BFC00004; assert rst_n low mid-run -> pc_addr=BFC00000, valid=0 immediately.
//   2 Stall 3 cycles at pc_addr=BFC00008 -> instr_out/pc_out/pc_addr unchanged all 3; release ->
//     pc_out=BFC00008, pc_addr=BFC0000C.
//   3 branch_taken, target BFC00100, pc_addr=BFC00008 -> next edge pc_out=BFC00008,
//     delay_slot=1, pc_addr=BFC00100; following edge pc_out=BFC00100, delay_slot=0.
//   4 branch_taken with stall=1 (target BFC00200), stall 2 more cycles, release -> delay slot
//     issues once with delay_slot=1, then pc_out=BFC00200; no duplicate/lost branch.
//   5 jr to 0 (target 0) -> delay slot issues, pc_addr=0, next edge active=0, valid=0;
//     later stall/branch pulses leave all outputs unchanged.
//   6 branch_target=BFC00102 -> addr_error=1, active=0 next edge, pc_addr frozen at prior value.

Source files
------------

// File: rtl/instr_fetch.sv
// PC/fetch stage: owns the program counter, addresses instr_mem combinationally and
// registers the returned word for decode, with delay-slot, stall, halt and trap sequencing.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_addr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        delay_slot,
  output logic        active,
  output logic        addr_error
);

  typedef enum logic [1:0] {
    RUN,
    PEND,
    HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        valid_q, valid_d;
  logic        ds_q, ds_d;
  logic        active_q, active_d;
  logic        addr_error_q, addr_error_d;

  // Per-edge decision: does an instruction issue, is the PC load a jump, and where to.
  logic        issue;
  logic        jump;
  logic [31:0] dest;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    pend_target_d = pend_target_q;
    valid_d       = valid_q;
    ds_d          = ds_q;
    active_d      = active_q;
    addr_error_d  = addr_error_q;
    issue         = 1'b0;
    jump          = 1'b0;
    dest          = pc_q + 32'd4;

    unique case (state_q)
      RUN: begin
        if (stall) begin
          if (branch_taken) begin
            pend_target_d = branch_target;
            state_d       = PEND;
          end
        end else begin
          issue = 1'b1;
          jump  = branch_taken;
          if (branch_taken) dest = branch_target;
        end
      end
      PEND: begin
        // Decode keeps presenting the same branch while stalled, so branch_taken is ignored.
        if (!stall) begin
          issue = 1'b1;
          jump  = 1'b1;
          dest  = pend_target_q;
        end
      end
      HALTED: begin
        valid_d  = 1'b0;
        ds_d     = 1'b0;
        active_d = 1'b0;
      end
      default: state_d = HALTED;
    endcase

    // The delay slot (or sequential word) always issues, even on a trapping or halting edge.
    if (issue) begin
      instr_d  = instr_in;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      ds_d     = jump;
      state_d  = RUN;
      if (jump && (dest[1:0] != 2'b00)) begin
        addr_error_d = 1'b1;
        state_d      = HALTED;
      end else begin
        pc_d = dest;
        if (dest == HALT_ADDR) state_d = HALTED;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'd0;
      pc_out_q      <= 32'd0;
      pend_target_q <= 32'd0;
      valid_q       <= 1'b0;
      ds_q          <= 1'b0;
      active_q      <= 1'b1;
      addr_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      pend_target_q <= pend_target_d;
      valid_q       <= valid_d;
      ds_q          <= ds_d;
      active_q      <= active_d;
      addr_error_q  <= addr_error_d;
    end
  end

  assign pc_addr     = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign delay_slot  = ds_q;
  assign active      = active_q;
  assign addr_error  = addr_error_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized stall/branch traffic compared
// against a behavioural program-flow model.
module tb_instr_fetch;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] instr_in;
  logic [31:0] pc_addr, instr_out, pc_out;
  logic        instr_valid, delay_slot, active, addr_error;

  int total = 0;
  int bad = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_in(instr_in), .pc_addr(pc_addr),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .delay_slot(delay_slot), .active(active), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  assign instr_in = word_at(pc_addr);

  // Behavioural model: program flow with an outstanding-branch flag.
  logic [31:0] m_pc, m_instr, m_pcout, m_pend_tgt;
  logic        m_valid, m_ds, m_active, m_err, m_halted, m_pend;

  task automatic model_reset();
    m_pc = RV; m_instr = 0; m_pcout = 0; m_pend_tgt = 0;
    m_valid = 0; m_ds = 0; m_active = 1; m_err = 0; m_halted = 0; m_pend = 0;
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    logic        is_jump;
    if (m_halted) begin
      m_valid = 0; m_ds = 0; m_active = 0;
    end else if (stall) begin
      if (!m_pend && branch_taken) begin
        m_pend = 1; m_pend_tgt = branch_target;
      end
    end else begin
      m_instr = word_at(m_pc);
      m_pcout = m_pc;
      m_valid = 1;
      is_jump = m_pend || branch_taken;
      m_ds    = is_jump;
      nxt     = m_pend ? m_pend_tgt : (branch_taken ? branch_target : m_pc + 4);
      m_pend  = 0;
      if (is_jump && (nxt % 4 != 0)) begin
        m_err = 1; m_halted = 1;
      end else begin
        m_pc = nxt;
        if (nxt == 0) m_halted = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; stall = 0; branch_taken = 0; branch_target = 0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1 rst_n = 0;
    model_reset();
    #1;
    total++; if (pc_addr !== RV) begin bad++; $display("FAIL reset_pc_addr got=%h exp=%h", pc_addr, RV); end
    total++; if ({instr_valid, delay_slot, active, addr_error} !== 4'b0010) begin
      bad++; $display("FAIL reset_flags got=%b exp=0010", {instr_valid, delay_slot, active, addr_error}); end
    total++; if ({instr_out, pc_out} !== 64'd0) begin
      bad++; $display("FAIL reset_regs got=%h/%h exp=0/0", instr_out, pc_out); end
    @(negedge clk) rst_n = 1;
    tick();
    total++; if (pc_out !== RV) begin bad++; $display("FAIL first_pc_out got=%h exp=%h", pc_out, RV); end
    total++; if (instr_out !== word_at(RV)) begin bad++; $display("FAIL first_instr got=%h exp=%h", instr_out, word_at(RV)); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", instr_valid); end
    total++; if (pc_addr !== RV + 4) begin bad++; $display("FAIL first_pc_addr got=%h exp=%h", pc_addr, RV + 4); end
    tick();
    #2 rst_n = 0;
    model_reset();
    #1;
    total++; if (pc_addr !== RV || instr_valid !== 1'b0) begin
      bad++; $display("FAIL midrun_reset got pc=%h v=%b exp pc=%h v=0", pc_addr, instr_valid, RV); end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_addr !== RV + 8 || pc_out !== RV + 4 || instr_out !== word_at(RV + 4)) begin
        bad++; $display("FAIL stall_hold cyc=%0d got pc_addr=%h pc_out=%h instr=%h exp %h %h %h",
                        i, pc_addr, pc_out, instr_out, RV + 8, RV + 4, word_at(RV + 4)); end
    end
    stall = 0;
    tick();
    total++; if (pc_out !== RV + 8 || pc_addr !== RV + 12) begin
      bad++; $display("FAIL stall_release got pc_out=%h pc_addr=%h exp %h %h", pc_out, pc_addr, RV + 8, RV + 12); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick();
    branch_taken = 1; branch_target = RV + 32'h100;
    tick();
    branch_taken = 0;
    total++; if (pc_out !== RV + 8 || delay_slot !== 1'b1 || pc_addr !== RV + 32'h100) begin
      bad++; $display("FAIL branch_slot got pc_out=%h ds=%b pc_addr=%h exp %h 1 %h",
                      pc_out, delay_slot, pc_addr, RV + 8, RV + 32'h100); end
    tick();
    total++; if (pc_out !== RV + 32'h100 || delay_slot !== 1'b0) begin
      bad++; $display("FAIL branch_target got pc_out=%h ds=%b exp %h 0", pc_out, delay_slot, RV + 32'h100); end
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    tick(); tick();
    stall = 1; branch_taken = 1; branch_target = RV + 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_addr !== RV + 8 || pc_out !== RV + 4 || delay_slot !== 1'b0) begin
        bad++; $display("FAIL pend_hold cyc=%0d got pc_addr=%h pc_out=%h ds=%b exp %h %h 0",
                        i, pc_addr, pc_out, delay_slot, RV + 8, RV + 4); end
    end
    stall = 0;
    tick();
    branch_taken = 0;
    total++; if (pc_out !== RV + 8 || delay_slot !== 1'b1 || pc_addr !== RV + 32'h200) begin
      bad++; $display("FAIL pend_slot got pc_out=%h ds=%b pc_addr=%h exp %h 1 %h",
                      pc_out, delay_slot, pc_addr, RV + 8, RV + 32'h200); end
    tick();
    total++; if (pc_out !== RV + 32'h200 || delay_slot !== 1'b0 || pc_addr !== RV + 32'h204) begin
      bad++; $display("FAIL pend_target got pc_out=%h ds=%b pc_addr=%h exp %h 0 %h",
                      pc_out, delay_slot, pc_addr, RV + 32'h200, RV + 32'h204); end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    branch_taken = 1; branch_target = 32'd0;
    tick();
    branch_taken = 0;
    total++; if (pc_addr !== 32'd0 || delay_slot !== 1'b1 || instr_valid !== 1'b1 || active !== 1'b1) begin
      bad++; $display("FAIL halt_slot got pc_addr=%h ds=%b v=%b act=%b exp 0 1 1 1",
                      pc_addr, delay_slot, instr_valid, active); end
    tick();
    total++; if (active !== 1'b0 || instr_valid !== 1'b0 || delay_slot !== 1'b0) begin
      bad++; $display("FAIL halt_state got act=%b v=%b ds=%b exp 0 0 0", active, instr_valid, delay_slot); end
    for (int i = 0; i < 5; i++) begin
      stall = $urandom_range(0, 1); branch_taken = 1; branch_target = RV + (i << 4);
      tick();
      total++; if (pc_addr !== 0 || pc_out !== RV + 4 || instr_out !== word_at(RV + 4) ||
                   active !== 1'b0 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL halt_frozen cyc=%0d got pc_addr=%h pc_out=%h act=%b v=%b exp 0 %h 0 0",
                        i, pc_addr, pc_out, active, instr_valid, RV + 4); end
    end
    stall = 0; branch_taken = 0;
  endtask

  task automatic test_misaligned();
    do_reset();
    tick(); tick();
    branch_taken = 1; branch_target = RV + 32'h102;
    tick();
    branch_taken = 0;
    total++; if (addr_error !== 1'b1 || pc_addr !== RV + 8 || pc_out !== RV + 8 || delay_slot !== 1'b1) begin
      bad++; $display("FAIL misalign_edge got err=%b pc_addr=%h pc_out=%h ds=%b exp 1 %h %h 1",
                      addr_error, pc_addr, pc_out, delay_slot, RV + 8, RV + 8); end
    tick();
    total++; if (active !== 1'b0 || addr_error !== 1'b1 || pc_addr !== RV + 8) begin
      bad++; $display("FAIL misalign_halt got act=%b err=%b pc_addr=%h exp 0 1 %h",
                      active, addr_error, pc_addr, RV + 8); end
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall        = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 20);
      case ($urandom_range(0, 19))
        0:       branch_target = 32'd0;
        1:       branch_target = RV + ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
        2, 3:    branch_target = 32'hFFFFFFF8;
        default: branch_target = RV + ($urandom_range(0, 255) << 2);
      endcase
      tick();
      total++; if (pc_addr !== m_pc) begin bad++; $display("FAIL rnd_pc_addr cyc=%0d got=%h exp=%h", i, pc_addr, m_pc); end
      total++; if (instr_out !== m_instr) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, instr_out, m_instr); end
      total++; if (pc_out !== m_pcout) begin bad++; $display("FAIL rnd_pc_out cyc=%0d got=%h exp=%h", i, pc_out, m_pcout); end
      total++; if ({instr_valid, delay_slot, active, addr_error} !== {m_valid, m_ds, m_active, m_err}) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i,
                        {instr_valid, delay_slot, active, addr_error}, {m_valid, m_ds, m_active, m_err}); end
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
      if (halt_cycles > 3) begin
        do_reset();
        halt_cycles = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    test_reset();
    test_stall();
    test_branch();
    test_branch_in_stall();
    test_halt();
    test_misaligned();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
